// File: rtl/downsampler_pkg.sv
// Shared types and defaults for the RX symbol downsampler.
// Provides FSM encoding, default widths and saturation bounds.
package downsampler_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_CNT_W  = 4;

  localparam int SAT_MAX = 2 ** (DEF_DATA_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_DATA_W - 1));

  localparam logic [DEF_DATA_W-1:0] ZERO_PAD = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/downsampler_sat_accum.sv
// Integrate-and-dump accumulator with signed saturation of the running sum.
// Ports: clk, rst_n, en (advance), restart (period start), sample -> sum_sat.
module downsampler_sat_accum
  import downsampler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_DATA_W + DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     restart,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] sum_sat
);

  localparam logic signed [ACC_W-1:0] HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    ext = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};
    sum = restart ? ext : acc_q + ext;
  end

  always_comb begin
    sum_sat = sum[DATA_W-1:0];
    unique case (1'b1)
      (sum > HI): sum_sat = HI[DATA_W-1:0];
      (sum < LO): sum_sat = LO[DATA_W-1:0];
      default:    sum_sat = sum[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (en) acc_q <= sum;
  end

endmodule

// File: rtl/downsampler.sv
// Symbol-rate downsampler: pick or integrate-and-dump over a synced period.
// Ports: enable/sync/mode/sample_rate/phase, I/Q in -> I/Q out, valid, locked.
module downsampler
  import downsampler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     sync,
  input  logic                     mode,
  input  logic [CNT_W-1:0]         sample_rate,
  input  logic [CNT_W-1:0]         phase,
  input  logic signed [DATA_W-1:0] input_data_1,
  input  logic signed [DATA_W-1:0] input_data_2,
  output logic signed [DATA_W-1:0] output_data_1,
  output logic signed [DATA_W-1:0] output_data_2,
  output logic                     symbol_valid,
  output logic                     locked
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] rate_q, phase_q, count_q;
  logic [CNT_W-1:0] rate_in, phase_in;
  logic [CNT_W-1:0] rate_c, phase_c, idx, cnt_d;
  logic             mode_q, mode_c;
  logic             start, active, last, cap;
  logic signed [DATA_W-1:0] sat_i, sat_q;

  always_comb begin
    rate_in = (sample_rate <= CNT_W'(1)) ? CNT_W'(1) : sample_rate;
    phase_in = (phase >= rate_in) ? rate_in - CNT_W'(1) : phase;
  end

  // The sync sample is index 0 of a fresh period using the new settings.
  always_comb begin
    start   = enable & sync;
    active  = enable & (sync | (state_q == S_RUN));
    rate_c  = start ? rate_in : rate_q;
    phase_c = start ? phase_in : phase_q;
    idx     = start ? '0 : count_q;
    mode_c  = (idx == '0) ? mode : mode_q;
    last    = (idx == rate_c - CNT_W'(1));
    cnt_d   = last ? '0 : idx + CNT_W'(1);
    cap     = active & (mode_c ? last : (idx == phase_c));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rate_q  <= CNT_W'(1);
      phase_q <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        rate_q  <= rate_in;
        phase_q <= phase_in;
      end
      if (active) begin
        count_q <= cnt_d;
        if (idx == '0) mode_q <= mode;
      end
    end
  end

  downsampler_sat_accum #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (active),
    .restart (idx == '0),
    .sample  (input_data_1),
    .sum_sat (sat_i)
  );

  downsampler_sat_accum #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (active),
    .restart (idx == '0),
    .sample  (input_data_2),
    .sum_sat (sat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_data_1 <= '0;
      output_data_2 <= '0;
      symbol_valid  <= 1'b0;
    end else begin
      symbol_valid <= cap;
      if (cap) begin
        output_data_1 <= mode_c ? sat_i : input_data_1;
        output_data_2 <= mode_c ? sat_q : input_data_2;
      end
    end
  end

  assign locked = (state_q == S_RUN);

endmodule

// File: tb/tb_downsampler.sv
// Directed + random bench for downsampler against a period-level model.
// Model keeps each period's samples in queues and derives symbols from them.
module tb_downsampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, sync, mode;
  logic [3:0] sample_rate, phase;
  logic [3:0] din1, din2, dout1, dout2;
  logic       valid, locked;

  int passes = 0;
  int total  = 0;

  bit         m_run, m_mode;
  int         m_rate, m_phase, m_n;
  int         qi[$], qq[$];
  logic [3:0] e1, e2;
  logic       e_valid;

  always #5 clk = ~clk;

  downsampler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sync          (sync),
    .mode          (mode),
    .sample_rate   (sample_rate),
    .phase         (phase),
    .input_data_1  (din1),
    .input_data_2  (din2),
    .output_data_1 (dout1),
    .output_data_2 (dout2),
    .symbol_valid  (valid),
    .locked        (locked)
  );

  initial begin
    #200000;
    $error("FAIL timeout got running exp finished");
    $fatal(1);
  end

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  function automatic int clamp(int s);
    if (s > 7) return 7;
    if (s < -8) return -8;
    return s;
  endfunction

  task automatic mreset();
    m_run = 0; m_mode = 0; m_rate = 1; m_phase = 0; m_n = 0;
    qi.delete(); qq.delete();
    e1 = '0; e2 = '0; e_valid = 1'b0;
  endtask

  task automatic model(bit en, bit sy, bit md, int rate, int ph,
                       int si, int sq);
    int pos, s1, s2;
    e_valid = 1'b0;
    if (en && (sy || m_run)) begin
      if (sy) begin
        m_rate  = (rate <= 1) ? 1 : rate;
        m_phase = (ph >= m_rate) ? m_rate - 1 : ph;
        m_n     = 0;
      end
      pos = m_n % m_rate;
      if (pos == 0) begin
        qi.delete(); qq.delete();
        m_mode = md;
      end
      qi.push_back(si);
      qq.push_back(sq);
      if (!m_mode && pos == m_phase) begin
        e1 = si[3:0]; e2 = sq[3:0]; e_valid = 1'b1;
      end
      if (m_mode && pos == m_rate - 1) begin
        s1 = 0; s2 = 0;
        foreach (qi[k]) s1 += qi[k];
        foreach (qq[k]) s2 += qq[k];
        s1 = clamp(s1); s2 = clamp(s2);
        e1 = s1[3:0]; e2 = s2[3:0]; e_valid = 1'b1;
      end
      m_n++;
    end
    if (!en) m_run = 0;
    else if (sy) m_run = 1;
  endtask

  task automatic cyc(bit en, bit sy, bit md, int rate, int ph,
                     int si, int sq);
    enable = en; sync = sy; mode = md;
    sample_rate = rate[3:0]; phase = ph[3:0];
    din1 = si[3:0]; din2 = sq[3:0];
    model(en, sy, md, rate, ph, si, sq);
    @(posedge clk);
    #1;
    chk("out1", {4'h0, dout1}, {4'h0, e1});
    chk("out2", {4'h0, dout2}, {4'h0, e2});
    chk("valid", {7'h0, valid}, {7'h0, e_valid});
    chk("locked", {7'h0, locked}, {7'h0, m_run});
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 0; sync = 0; mode = 0;
    sample_rate = 0; phase = 0; din1 = 0; din2 = 0;
    mreset();
    #2;
    chk("rst_out1", {4'h0, dout1}, 8'h0);
    chk("rst_valid", {7'h0, valid}, 8'h0);
    chk("rst_locked", {7'h0, locked}, 8'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cyc(0, 1, 0, 4, 0, 3, 3);
    chk("idle_sync_ignored", {7'h0, locked}, 8'h0);

    // pick rate 4 phase 0
    cyc(1, 1, 0, 4, 0, 5, 0);
    chk("t1_first", {4'h0, dout1}, 8'h05);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, -3, 0);
    chk("t1_second", {4'h0, dout1}, 8'h0D);
    chk("t1_locked", {7'h0, locked}, 8'h01);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, 0, 0);

    // integrate rate 4, symbol two samples after sync
    cyc(1, 1, 1, 4, 0, 0, 0);
    cyc(1, 0, 1, 4, 0, 0, 0);
    cyc(1, 0, 1, 4, 0, 6, 0);
    cyc(1, 0, 1, 4, 0, 0, 0);
    chk("t2_dump", {4'h0, dout1}, 8'h06);
    cyc(1, 0, 1, 4, 0, 0, 0);
    cyc(1, 0, 1, 4, 0, 0, 0);

    // same stream, pick phase 2
    cyc(1, 1, 0, 4, 2, 0, 0);
    cyc(1, 0, 0, 4, 2, 0, 0);
    cyc(1, 0, 0, 4, 2, 6, 0);
    chk("t2_pick", {4'h0, dout1}, 8'h06);
    cyc(1, 0, 0, 4, 2, 0, 0);

    // saturation
    cyc(1, 1, 1, 4, 0, 7, -8);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 4, 0, 7, -8);
    chk("t3_sat_hi", {4'h0, dout1}, 8'h07);
    chk("t3_sat_lo", {4'h0, dout2}, 8'h08);
    cyc(1, 0, 1, 4, 0, 3, 0);
    cyc(1, 0, 1, 4, 0, 3, 0);
    cyc(1, 0, 1, 4, 0, -2, 0);
    cyc(1, 0, 1, 4, 0, 0, 0);
    chk("t3_sum", {4'h0, dout1}, 8'h04);

    // rate 1 and rate 0
    cyc(1, 1, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 2, 0);
    cyc(1, 0, 0, 1, 0, 3, 0);
    chk("t4_r1", {4'h0, dout1}, 8'h03);
    cyc(1, 1, 1, 0, 5, 1, 2);
    cyc(1, 0, 1, 0, 5, 2, 3);
    cyc(1, 0, 1, 0, 5, 3, 4);
    chk("t4_r0_valid", {7'h0, valid}, 8'h01);

    // resync mid-period
    cyc(1, 1, 0, 8, 5, 1, 1);
    cyc(1, 0, 0, 8, 5, 2, 2);
    cyc(1, 1, 0, 8, 5, 3, 3);
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 8, 5, k - 4, k);
    cyc(1, 1, 0, 4, 9, 1, 1);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 4, 9, k, -k);

    // disable drops valid, holds outputs
    cyc(0, 0, 0, 4, 0, 5, 5);
    cyc(0, 0, 0, 4, 0, 5, 5);

    // reset mid-run
    cyc(1, 1, 1, 3, 0, 2, 2);
    cyc(1, 0, 1, 3, 0, 2, 2);
    cyc(1, 0, 1, 3, 0, 2, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_out1", {4'h0, dout1}, 8'h0);
    chk("t6_valid", {7'h0, valid}, 8'h0);
    chk("t6_locked", {7'h0, locked}, 8'h0);
    mreset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 0, k, k);
    cyc(1, 1, 0, 2, 1, 4, 4);
    cyc(1, 0, 0, 2, 1, 5, 5);

    // random
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom_range(15) != 0), ($urandom_range(11) == 0),
          1'($urandom_range(1)),
          int'($urandom_range(15)), int'($urandom_range(15)),
          int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
